// File: rtl/pixl_pkg.sv
// pixl_pkg: shared state encoding, default geometry and width helper for the pixel-lane receiver
package pixl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } pixl_state_t;

    localparam int DEF_LANES       = 20;
    localparam int DEF_SAMPLES     = 25;
    localparam int DEF_LINES       = 500;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixl_sync_bit.sv
// pixl_sync_bit: single-bit flop-chain synchroniser with asynchronous clear
module pixl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic pixl_clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift d through the chain; asynchronous clear, synchronous release.
    always_ff @(posedge pixl_clk or negedge rstn) begin
        if (!rstn) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pixl_receive_gen.sv
// pixl_receive_gen: lane deserialiser producing validated line words and frame bookkeeping
module pixl_receive_gen
    import pixl_pkg::*;
#(
    parameter  int LANES       = DEF_LANES,
    parameter  int SAMPLES     = DEF_SAMPLES,
    parameter  int LINES       = DEF_LINES,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int SCNT_W      = cnt_w(SAMPLES),
    localparam int LINE_W      = cnt_w(LINES)
) (
    input  logic                       pixl_clk,
    input  logic                       rstn,
    input  logic [LANES-1:0]           pix_bit,
    input  logic                       frame_in,
    input  logic                       frame_en,
    output logic [LANES*SAMPLES-1:0]   data_out,
    output logic [LINE_W-1:0]          line_idx,
    output logic                       data_valid,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       frame_det,
    output logic                       sync_err
);

    logic                     rst_n_i;
    logic                     en_s;
    logic                     en_s_d;
    logic [LANES-1:0]         pix_q;
    logic [LANES-1:0]         pix_d;
    logic                     frame_q;
    logic                     frame_q_d;
    logic                     mark;
    pixl_state_t              state;
    pixl_state_t              state_nx;
    logic [SCNT_W-1:0]        scnt;
    logic [LINE_W-1:0]        lcnt;
    logic                     start;
    logic                     eol;
    logic                     last;
    logic                     err;
    logic [LANES*SAMPLES-1:0] line_word;

    pixl_sync_bit #(.STAGES(2)) u_rst_sync (
        .pixl_clk (pixl_clk),
        .rstn     (rstn),
        .d        (1'b1),
        .q        (rst_n_i)
    );

    pixl_sync_bit #(.STAGES(SYNC_STAGES)) u_en_sync (
        .pixl_clk (pixl_clk),
        .rstn     (rst_n_i),
        .d        (frame_en),
        .q        (en_s)
    );

    // Pin capture stage plus one alignment stage so lane data lines up with the marker decision.
    always_ff @(posedge pixl_clk) begin
        pix_q <= pix_bit;
        pix_d <= pix_q;
    end

    // Registered marker and enable history for edge detection.
    always_ff @(posedge pixl_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_q   <= 1'b0;
            frame_q_d <= 1'b0;
            en_s_d    <= 1'b0;
        end else begin
            frame_q   <= frame_in;
            frame_q_d <= frame_q;
            en_s_d    <= en_s;
        end
    end

    assign mark = frame_q & ~frame_q_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SAMPLES-2:0] sr;
        logic [SAMPLES-1:0] lw;
        assign lw = {pix_d[l], sr};
        assign line_word[l*SAMPLES +: SAMPLES] = lw;
        // Newest sample enters at the MSB so sample 0 settles at bit 0 when the line completes.
        always_ff @(posedge pixl_clk) begin
            if (state == CAPTURE) sr <= lw[SAMPLES-1:1];
        end
    end

    // Next-state decode: marker acceptance, line/frame completion and premature-marker detection.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        err      = 1'b0;
        eol      = (state == CAPTURE) && (scnt == SCNT_W'(SAMPLES - 1));
        last     = eol && (lcnt == LINE_W'(LINES - 1));
        case (state)
            IDLE: state_nx = en_s ? ARMED : IDLE;
            ARMED: begin
                start    = mark;
                state_nx = mark ? CAPTURE : (en_s ? ARMED : IDLE);
            end
            CAPTURE: begin
                start    = mark;
                err      = mark & ~last;
                state_nx = (mark || !last) ? CAPTURE : (en_s ? ARMED : IDLE);
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pixl_clk or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // Sample and line counters, cleared on every accepted marker.
    always_ff @(posedge pixl_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scnt <= '0;
            lcnt <= '0;
        end else if (start) begin
            scnt <= '0;
            lcnt <= '0;
        end else if (state == CAPTURE) begin
            scnt <= eol ? '0 : scnt + 1'b1;
            if (eol) lcnt <= last ? '0 : lcnt + 1'b1;
        end
    end

    // Output word/index load, status pulses and sticky flags.
    always_ff @(posedge pixl_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out    <= '0;
            line_idx    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_det   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            data_valid  <= eol;
            frame_start <= start;
            frame_done  <= last;
            frame_det   <= frame_det | mark;
            sync_err    <= err | (sync_err & ~(en_s & ~en_s_d));
            if (eol) begin
                data_out <= line_word;
                line_idx <= lcnt;
            end
        end
    end

endmodule

// File: tb/tb_pixl_receive_gen.sv
// tb_pixl_receive_gen: randomized and directed checks against a frame-level reference model
module tb_pixl_receive_gen;

    localparam int LANES = 4;
    localparam int S     = 5;
    localparam int L     = 3;
    localparam int LW    = 2;
    localparam int DW    = LANES * S;
    localparam int HN    = 8192;

    logic          pixl_clk = 1'b0;
    logic          rstn     = 1'b0;
    logic [3:0]    pix_bit  = '0;
    logic          frame_in = 1'b0;
    logic          frame_en = 1'b0;
    logic [DW-1:0] data_out;
    logic [LW-1:0] line_idx;
    logic          data_valid, frame_start, frame_done, frame_det, sync_err;

    pixl_receive_gen #(
        .LANES(LANES), .SAMPLES(S), .LINES(L), .SYNC_STAGES(2)
    ) dut (
        .pixl_clk    (pixl_clk),
        .rstn        (rstn),
        .pix_bit     (pix_bit),
        .frame_in    (frame_in),
        .frame_en    (frame_en),
        .data_out    (data_out),
        .line_idx    (line_idx),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_det   (frame_det),
        .sync_err    (sync_err)
    );

    always #5 pixl_clk = ~pixl_clk;

    // pin history, indexed by the cycle in which the value sat on the pins
    logic [3:0] h_pix [HN];
    bit         h_fr  [HN];
    bit         h_en  [HN];
    int         cyc = 8;

    // frame-level reference state
    bit            in_rst = 1'b1;
    bit            in_frame, armed, m_det, m_err;
    int            t0;
    logic [DW-1:0] m_word;
    int            m_line;
    bit            e_valid, e_fs, e_fd;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    endtask

    // Expected outputs for observation cycle cyc. A marker on the pins at cycle tm is
    // acted on so that its effects show at tm+2; a line ends once its last pin sample is
    // one cycle older than the decision, and frame_en is seen with a two-cycle lag.
    task automatic model_step();
        int  tm;
        bit  mark, en, enp, fin, err;
        e_valid = 0; e_fs = 0; e_fd = 0;
        if (in_rst) begin
            in_frame = 0; armed = 0; m_det = 0; m_err = 0; m_word = '0; m_line = 0;
            return;
        end
        tm   = cyc - 2;
        mark = h_fr[tm] && !h_fr[tm-1];
        en   = h_en[cyc-3];
        enp  = h_en[cyc-4];
        fin  = 0;
        err  = 0;
        if (in_frame) begin
            int p;
            p = tm - 1 - t0;
            if ((p + 1) % S == 0) begin
                int ln;
                ln = (p + 1) / S - 1;
                e_valid = 1;
                m_line  = ln;
                for (int l = 0; l < LANES; l++)
                    for (int k = 0; k < S; k++)
                        m_word[l*S+k] = h_pix[t0 + ln*S + k][l];
                if (ln == L - 1) begin
                    e_fd = 1; in_frame = 0; fin = 1;
                end
            end
        end
        m_det = m_det | mark;
        if (mark && (in_frame || armed || fin)) begin
            err = in_frame;
            e_fs = 1; in_frame = 1; t0 = tm;
        end else if (!in_frame) begin
            armed = en;
        end
        if (err) m_err = 1;
        else if (en && !enp) m_err = 0;
    endtask

    task automatic step(input logic [3:0] p, input bit f, input bit e);
        @(posedge pixl_clk);
        #1;
        cyc++;
        model_step();
        chk("data_valid",  data_valid,  e_valid);
        chk("frame_start", frame_start, e_fs);
        chk("frame_done",  frame_done,  e_fd);
        chk("frame_det",   frame_det,   m_det);
        chk("sync_err",    sync_err,    m_err);
        chk("data_out",    data_out,    m_word);
        chk("line_idx",    line_idx,    m_line);
        pix_bit = p; frame_in = f; frame_en = e;
        h_pix[cyc] = p; h_fr[cyc] = f; h_en[cyc] = e;
    endtask

    function automatic logic [3:0] rnd();
        return 4'($urandom_range(15));
    endfunction

    initial begin
        int         t_mk;
        logic [4:0] pat;
        bit         f, e;
        pat = 5'b01101;
        for (int i = 0; i < HN; i++) begin
            h_pix[i] = '0; h_fr[i] = 0; h_en[i] = 0;
        end

        // power-on reset
        for (int i = 0; i < 4; i++) step('0, 0, 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step('0, 0, 0);
        in_rst = 1'b0;
        chk("reset_valid", data_valid, 1'b0);
        chk("reset_det",   frame_det,  1'b0);

        // basic capture with a known lane-0 pattern
        for (int i = 0; i < 6; i++) step(rnd(), 0, 1);
        t_mk = cyc + 1;
        for (int i = 0; i < 26; i++) begin
            step({rnd() >> 1, pat[i%5]}, (i < 2) || (i == 22), 1);
            if (cyc == t_mk + 7) begin
                chk("s1_valid", data_valid, 1'b1);
                chk("s1_lane0", data_out[4:0], 5'b01101);
                chk("s1_idx0",  line_idx, 0);
            end
            if (cyc == t_mk + 12) chk("s1_idx1", line_idx, 1);
            if (cyc == t_mk + 17) begin
                chk("s1_idx2", line_idx, 2);
                chk("s1_done", frame_done, 1'b1);
            end
            if (cyc == t_mk + 24) chk("s1_rearm", frame_start, 1'b1);
        end

        // premature marker at line 1 sample 2
        for (int i = 0; i < 20; i++) step(rnd(), 0, 1);
        t_mk = cyc + 1;
        for (int i = 0; i < 26; i++) begin
            step(rnd(), (i < 2) || (i == 7), 1);
            if (cyc == t_mk + 9) begin
                chk("s2_err",   sync_err,    1'b1);
                chk("s2_start", frame_start, 1'b1);
            end
            if (cyc == t_mk + 12) chk("s2_nopartial", data_valid, 1'b0);
            if (cyc == t_mk + 14) begin
                chk("s2_valid", data_valid, 1'b1);
                chk("s2_idx0",  line_idx, 0);
            end
        end
        for (int i = 0; i < 5; i++) step(rnd(), 0, 1);
        chk("s2_err_sticky", sync_err, 1'b1);
        for (int i = 0; i < 5; i++) step(rnd(), 0, 0);
        for (int i = 0; i < 6; i++) step(rnd(), 0, 1);
        chk("s2_err_clear", sync_err, 1'b0);

        // frame_en dropped mid-frame
        t_mk = cyc + 1;
        for (int i = 0; i < 28; i++) begin
            step(rnd(), (i < 2) || (i == 20), i < 5);
            if (cyc == t_mk + 17) chk("s3_done", frame_done, 1'b1);
            if (cyc == t_mk + 22) begin
                chk("s3_ignored", frame_start, 1'b0);
                chk("s3_det",     frame_det,   1'b1);
            end
        end

        // back-to-back frames
        for (int i = 0; i < 5; i++) step(rnd(), 0, 1);
        t_mk = cyc + 1;
        for (int i = 0; i < 36; i++) begin
            step(rnd(), (i < 2) || (i == 15) || (i == 16), 1);
            if (cyc == t_mk + 17) begin
                chk("s4_done",  frame_done,  1'b1);
                chk("s4_start", frame_start, 1'b1);
            end
            if (cyc == t_mk + 22) begin
                chk("s4_valid", data_valid, 1'b1);
                chk("s4_idx0",  line_idx, 0);
            end
        end

        // reset mid-line
        for (int i = 0; i < 3; i++) step(rnd(), 0, 1);
        for (int i = 0; i < 9; i++) step(rnd(), i < 2, 1);
        #2;
        rstn = 1'b0;
        #1;
        in_rst = 1'b1;
        chk("s5_data", data_out,  '0);
        chk("s5_idx",  line_idx,  '0);
        chk("s5_det",  frame_det, 1'b0);
        chk("s5_vld",  data_valid, 1'b0);
        pix_bit = '0; frame_in = 0; frame_en = 0;
        for (int i = 0; i < 3; i++) step('0, 0, 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step('0, 0, 0);
        in_rst = 1'b0;
        for (int i = 0; i < 12; i++) step(rnd(), 0, 1);

        // randomized streaming with hold checks on every cycle
        f = 0; e = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) f = ~f;
            if ($urandom_range(79) == 0) e = ~e;
            step(rnd(), f, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
